// File: rtl/mmu_sfr_write_decoder.sv
// SFR write decoder for the MMU control and TLB entry registers.
// It merges SET/HFXB/HFXT writes and hands TLB write requests to the TLB through a level req/ack handshake.
module mmu_sfr_write_decoder #(
  parameter logic [7:0] IDX_MMC = 8'h20,
  parameter logic [7:0] IDX_TEL = 8'h21,
  parameter logic [7:0] IDX_TEH = 8'h22,
  parameter logic [7:0] IDX_TWC = 8'h23
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_wr_reg_en_i_m,
  input  logic [1:0]  cpu_wr_reg_cmd_i_m,
  input  logic [7:0]  cpu_wr_reg_idx_i_m,
  input  logic [31:0] cpu_wr_reg_val_i_m,
  output logic [31:0] mmc_o,
  output logic [31:0] tel_o,
  output logic [31:0] teh_o,
  output logic        tlb_wr_req_o,
  output logic [31:0] tlb_wr_tel_o,
  output logic [31:0] tlb_wr_teh_o,
  input  logic        tlb_wr_ack_i,
  output logic        err_o
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  localparam logic [1:0] CMD_SET  = 2'b00;
  localparam logic [1:0] CMD_HFXB = 2'b01;
  localparam logic [1:0] CMD_HFXT = 2'b10;
  localparam logic [1:0] CMD_RES  = 2'b11;

  // HFXB/HFXT: the upper half of val is a bit mask and the lower half is the data for one half-word.
  function automatic logic [31:0] mergeValue(input logic [31:0] old, input logic [1:0] cmd,
                                             input logic [31:0] val);
    logic [15:0] mask;
    logic [15:0] data;
    mask = val[31:16];
    data = val[15:0];
    case (cmd)
      CMD_SET:  mergeValue = val;
      CMD_HFXB: mergeValue = {old[31:16], (old[15:0] & ~mask) | (data & mask)};
      CMD_HFXT: mergeValue = {(old[31:16] & ~mask) | (data & mask), old[15:0]};
      default:  mergeValue = old;
    endcase
  endfunction

  state_t      r_state;
  state_t      w_stateNext;
  logic [31:0] r_mmc;
  logic [31:0] r_tel;
  logic [31:0] r_teh;
  logic [31:0] r_snapTel;
  logic [31:0] r_snapTeh;
  logic        r_err;

  logic        w_cmdOk;
  logic        w_hitMmc;
  logic        w_hitTel;
  logic        w_hitTeh;
  logic        w_hitTwc;
  logic        w_reject;
  logic [31:0] w_mmcMerged;
  logic [31:0] w_mmcNext;
  logic [31:0] w_telMerged;
  logic [31:0] w_tehMerged;
  logic [1:0]  w_twcBits;
  logic        w_issue;
  logic        w_clearE;
  logic        w_takeSnap;
  logic        w_overrun;
  logic        w_eNext;

  assign w_cmdOk  = cpu_wr_reg_en_i_m && (cpu_wr_reg_cmd_i_m != CMD_RES);
  assign w_hitMmc = w_cmdOk && (cpu_wr_reg_idx_i_m == IDX_MMC);
  assign w_hitTel = w_cmdOk && (cpu_wr_reg_idx_i_m == IDX_TEL);
  assign w_hitTeh = w_cmdOk && (cpu_wr_reg_idx_i_m == IDX_TEH);
  assign w_hitTwc = w_cmdOk && (cpu_wr_reg_idx_i_m == IDX_TWC);
  assign w_reject = cpu_wr_reg_en_i_m && !(w_hitMmc || w_hitTel || w_hitTeh || w_hitTwc);

  assign w_mmcMerged = mergeValue(r_mmc, cpu_wr_reg_cmd_i_m, cpu_wr_reg_val_i_m);
  assign w_telMerged = mergeValue(r_tel, cpu_wr_reg_cmd_i_m, cpu_wr_reg_val_i_m);
  assign w_tehMerged = mergeValue(r_teh, cpu_wr_reg_cmd_i_m, cpu_wr_reg_val_i_m);

  // TWC has no storage, so only bits 1:0 of a merge against zero matter.
  always_comb begin
    w_twcBits = 2'b00;
    case (cpu_wr_reg_cmd_i_m)
      CMD_SET:  w_twcBits = cpu_wr_reg_val_i_m[1:0];
      CMD_HFXB: w_twcBits = cpu_wr_reg_val_i_m[17:16] & cpu_wr_reg_val_i_m[1:0];
      default:  w_twcBits = 2'b00;
    endcase
  end

  assign w_issue  = w_hitTwc && w_twcBits[0];
  assign w_clearE = w_hitTwc && w_twcBits[1];

  always_comb begin
    w_stateNext = r_state;
    w_takeSnap  = 1'b0;
    w_overrun   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_issue) begin
          w_stateNext = PEND;
          w_takeSnap  = 1'b1;
        end
      end
      PEND: begin
        if (tlb_wr_ack_i && w_issue) begin
          w_takeSnap = 1'b1;
        end else if (tlb_wr_ack_i) begin
          w_stateNext = IDLE;
        end else if (w_issue) begin
          w_overrun = 1'b1;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // The overrun set takes priority over a clear in the same TWC write.
  always_comb begin
    w_eNext = r_mmc[31];
    if (w_overrun) begin
      w_eNext = 1'b1;
    end else if (w_clearE) begin
      w_eNext = 1'b0;
    end
    w_mmcNext     = w_hitMmc ? w_mmcMerged : r_mmc;
    w_mmcNext[31] = w_eNext;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_mmc     <= 32'h0;
      r_tel     <= 32'h0;
      r_teh     <= 32'h0;
      r_snapTel <= 32'h0;
      r_snapTeh <= 32'h0;
      r_err     <= 1'b0;
    end else begin
      r_mmc <= w_mmcNext;
      if (w_hitTel) begin
        r_tel <= w_telMerged;
      end
      if (w_hitTeh) begin
        r_teh <= w_tehMerged;
      end
      if (w_takeSnap) begin
        r_snapTel <= r_tel;
        r_snapTeh <= r_teh;
      end
      r_err <= w_reject || w_overrun;
    end
  end

  assign mmc_o        = r_mmc;
  assign tel_o        = r_tel;
  assign teh_o        = r_teh;
  assign tlb_wr_req_o = (r_state == PEND);
  assign tlb_wr_tel_o = r_snapTel;
  assign tlb_wr_teh_o = r_snapTeh;
  assign err_o        = r_err;

endmodule

// File: tb/tb_mmu_sfr_write_decoder.sv
// Scoreboard bench for mmu_sfr_write_decoder: the driver pushes the reference model's expected outputs per cycle,
// and the monitor pops them and compares them after each rising edge.
module tb_mmu_sfr_write_decoder;

  typedef struct packed {
    logic [31:0] mmc;
    logic [31:0] tel;
    logic [31:0] teh;
    logic        req;
    logic [31:0] snapTel;
    logic [31:0] snapTeh;
    logic        err;
  } outs_t;

  logic        clock;
  logic        reset;
  logic        wrEn;
  logic [1:0]  wrCmd;
  logic [7:0]  wrIdx;
  logic [31:0] wrVal;
  logic        ack;
  logic [31:0] mmcOut;
  logic [31:0] telOut;
  logic [31:0] tehOut;
  logic        reqOut;
  logic [31:0] snapTelOut;
  logic [31:0] snapTehOut;
  logic        errOut;

  outs_t expQ[$];
  int    checks = 0;
  int    errors = 0;

  logic [31:0] mMmc, mTel, mTeh, mSnapTel, mSnapTeh;
  logic        mPend, mErr;

  mmu_sfr_write_decoder dut (
    .clock              (clock),
    .reset              (reset),
    .cpu_wr_reg_en_i_m  (wrEn),
    .cpu_wr_reg_cmd_i_m (wrCmd),
    .cpu_wr_reg_idx_i_m (wrIdx),
    .cpu_wr_reg_val_i_m (wrVal),
    .mmc_o              (mmcOut),
    .tel_o              (telOut),
    .teh_o              (tehOut),
    .tlb_wr_req_o       (reqOut),
    .tlb_wr_tel_o       (snapTelOut),
    .tlb_wr_teh_o       (snapTehOut),
    .tlb_wr_ack_i       (ack),
    .err_o              (errOut)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference merge in plain arithmetic: the mask selects which data bits replace the old half-word.
  function automatic logic [31:0] refMerge(input logic [31:0] old, input logic [1:0] cmd, input logic [31:0] val);
    logic [31:0] m, d;
    m = {16'h0, val[31:16]};
    d = {16'h0, val[15:0]};
    if (cmd == 2'd0) return val;
    if (cmd == 2'd1) return (old & ~m) | (d & m);
    if (cmd == 2'd2) return (old & ~(m << 16)) | ((d & m) << 16);
    return old;
  endfunction

  task automatic modelStep(input logic rstN, input logic en, input logic [1:0] cmd, input logic [7:0] idx,
                           input logic [31:0] val, input logic ackIn);
    logic [31:0] merged;
    logic        go, clr, ovr;
    mErr = 1'b0;
    if (!rstN) begin
      {mMmc, mTel, mTeh, mSnapTel, mSnapTeh} = '0;
      mPend = 1'b0;
      return;
    end
    go = 1'b0; clr = 1'b0; ovr = 1'b0;
    if (en) begin
      if (cmd == 2'd3 || idx < 8'h20 || idx > 8'h23) begin
        mErr = 1'b1;
      end else if (idx == 8'h20) begin
        merged = refMerge(mMmc, cmd, val);
        mMmc = {mMmc[31], merged[30:0]};
      end else if (idx == 8'h21) begin
        mTel = refMerge(mTel, cmd, val);
      end else if (idx == 8'h22) begin
        mTeh = refMerge(mTeh, cmd, val);
      end else begin
        merged = refMerge(32'h0, cmd, val);
        go = merged[0];
        clr = merged[1];
      end
    end
    if (go && (!mPend || ackIn)) begin
      mPend = 1'b1;
      mSnapTel = mTel;
      mSnapTeh = mTeh;
    end else if (go) begin
      ovr = 1'b1;
    end else if (mPend && ackIn) begin
      mPend = 1'b0;
    end
    if (ovr) begin
      mErr = 1'b1;
      mMmc[31] = 1'b1;
    end else if (clr) begin
      mMmc[31] = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic rstN, input logic en, input logic [1:0] cmd, input logic [7:0] idx,
                               input logic [31:0] val, input logic ackIn);
    outs_t e;
    @(negedge clock);
    reset = rstN;
    wrEn  = en;
    wrCmd = cmd;
    wrIdx = idx;
    wrVal = val;
    ack   = ackIn;
    modelStep(rstN, en, cmd, idx, val, ackIn);
    e = '{mmc: mMmc, tel: mTel, teh: mTeh, req: mPend, snapTel: mSnapTel, snapTeh: mSnapTeh, err: mErr};
    expQ.push_back(e);
  endtask

  task automatic settle();
    @(posedge clock);
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  initial begin : monitor
    outs_t e, a;
    forever begin
      @(posedge clock);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        a = '{mmc: mmcOut, tel: telOut, teh: tehOut, req: reqOut, snapTel: snapTelOut,
              snapTeh: snapTehOut, err: errOut};
        checks++;
        if (a !== e) begin
          errors++;
          $display("[TB] FAIL cycle@%0t: got mmc=%h tel=%h teh=%h req=%b snap=%h/%h err=%b expected mmc=%h tel=%h teh=%h req=%b snap=%h/%h err=%b",
                   $time, a.mmc, a.tel, a.teh, a.req, a.snapTel, a.snapTeh, a.err,
                   e.mmc, e.tel, e.teh, e.req, e.snapTel, e.snapTeh, e.err);
        end
      end
    end
  end

  initial begin : driver
    logic [7:0]  idx;
    logic [31:0] val;
    {reset, wrEn, wrCmd, wrIdx, wrVal, ack} = '0;
    {mMmc, mTel, mTeh, mSnapTel, mSnapTeh, mPend, mErr} = '0;

    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd0, 8'h21, 32'hDEADBEEF, 1'b0);
    settle();
    checkOutput("resetTel", telOut, 32'h0);
    checkOutput("resetReq", {31'h0, reqOut}, 32'h0);

    applyStimulus(1'b1, 1'b1, 2'd0, 8'h21, 32'h12345678, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd1, 8'h21, 32'h00FF00AB, 1'b0);
    settle();
    checkOutput("hfxbTel", telOut, 32'h123456AB);
    applyStimulus(1'b1, 1'b1, 2'd2, 8'h21, 32'hF0000000, 1'b0);
    settle();
    checkOutput("hfxtTel", telOut, 32'h023456AB);

    applyStimulus(1'b1, 1'b1, 2'd0, 8'h21, 32'hA, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd0, 8'h22, 32'hB, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd0, 8'h23, 32'h1, 1'b0);
    settle();
    checkOutput("reqIssued", {31'h0, reqOut}, 32'h1);
    checkOutput("snapTel", snapTelOut, 32'hA);
    checkOutput("snapTeh", snapTehOut, 32'hB);
    applyStimulus(1'b1, 1'b1, 2'd0, 8'h21, 32'hC, 1'b0);
    settle();
    checkOutput("snapHeld", snapTelOut, 32'hA);
    checkOutput("telInPend", telOut, 32'hC);
    applyStimulus(1'b1, 1'b0, 2'd0, 8'h00, 32'h0, 1'b1);
    settle();
    checkOutput("reqAcked", {31'h0, reqOut}, 32'h0);

    applyStimulus(1'b1, 1'b1, 2'd0, 8'h23, 32'h1, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd0, 8'h23, 32'h1, 1'b0);
    settle();
    checkOutput("overrunErr", {31'h0, errOut}, 32'h1);
    checkOutput("overrunE", {31'h0, mmcOut[31]}, 32'h1);
    checkOutput("overrunSnap", snapTelOut, 32'hC);
    applyStimulus(1'b1, 1'b1, 2'd0, 8'h23, 32'h2, 1'b0);
    settle();
    checkOutput("errOneCycle", {31'h0, errOut}, 32'h0);
    checkOutput("clearE", {31'h0, mmcOut[31]}, 32'h0);
    applyStimulus(1'b1, 1'b1, 2'd0, 8'h23, 32'h3, 1'b0);
    settle();
    checkOutput("setWinsClear", {31'h0, mmcOut[31]}, 32'h1);
    applyStimulus(1'b1, 1'b1, 2'd0, 8'h23, 32'h2, 1'b1);

    applyStimulus(1'b1, 1'b1, 2'd3, 8'h20, 32'hFFFFFFFF, 1'b0);
    settle();
    checkOutput("resCmdErr", {31'h0, errOut}, 32'h1);
    checkOutput("resCmdMmc", mmcOut, 32'h0);
    applyStimulus(1'b1, 1'b1, 2'd0, 8'h55, 32'hFFFFFFFF, 1'b0);
    settle();
    checkOutput("badIdxErr", {31'h0, errOut}, 32'h1);
    applyStimulus(1'b1, 1'b1, 2'd0, 8'h20, 32'hFFFFFFFF, 1'b0);
    settle();
    checkOutput("mmcRoE", mmcOut, 32'h7FFFFFFF);

    applyStimulus(1'b1, 1'b1, 2'd0, 8'h23, 32'h1, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd0, 8'h21, 32'h11, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd0, 8'h23, 32'h1, 1'b1);
    settle();
    checkOutput("ackReissueReq", {31'h0, reqOut}, 32'h1);
    checkOutput("ackReissueSnap", snapTelOut, 32'h11);
    checkOutput("ackReissueErr", {31'h0, errOut}, 32'h0);
    applyStimulus(1'b0, 1'b1, 2'd0, 8'h21, 32'h99, 1'b0);
    settle();
    checkOutput("resetPendReq", {31'h0, reqOut}, 32'h0);
    checkOutput("resetPendMmc", mmcOut, 32'h0);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0: idx = 8'h20;
        1: idx = 8'h21;
        2: idx = 8'h22;
        3: idx = 8'h23;
        default: idx = 8'($urandom);
      endcase
      val = $urandom;
      if (idx == 8'h23 && $urandom_range(0, 1) == 1) val = val & 32'h00030003;
      applyStimulus(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) != 0), 2'($urandom),
                    idx, val, ($urandom_range(0, 2) == 0));
    end

    applyStimulus(1'b1, 1'b0, 2'd0, 8'h00, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'd0, 8'h00, 32'h0, 1'b0);
    settle();
    checkOutput("scoreboardDrained", 32'(expQ.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
